// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer: pulses the PLL RST pin, waits for a stable LOCKED and
// releases a registered system reset. Optional soft reset request port enabled by PLL_SEQ_SOFT_RST_EN.
module pll_reset_sequencer #(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 64,
   parameter int LOCK_TIMEOUT_CYCLES = 4096,
   parameter int SYNC_STAGES         = 2
) (
   input  logic       clk,
   input  logic       cpu_reset_n,
   input  logic       pll_locked,
`ifdef PLL_SEQ_SOFT_RST_EN
   input  logic       soft_rst_req,
`endif
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [3:0] retry_count,
   output logic       timeout_err
);

   localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RESET_PLL = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : (v + 4'd1);
   endfunction

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pll_rst_q;
   logic                   sys_rst_q;
   logic                   ready_q;
   logic [3:0]             retry_q;
   logic                   timeout_err_q;
   logic                   locked_s;
   logic                   soft_req_d;

`ifdef PLL_SEQ_SOFT_RST_EN
   assign soft_req_d = soft_rst_req;
`else
   assign soft_req_d = 1'b0;
`endif

   // Bring the asynchronous LOCKED into the clk domain.
   always_ff @(posedge clk) begin
      if (!cpu_reset_n) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Sequencer FSM; outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (!cpu_reset_n) begin
         state_q       <= S_RESET_PLL;
         cnt_q         <= CNT_ZERO;
         pll_rst_q     <= 1'b1;
         sys_rst_q     <= 1'b1;
         ready_q       <= 1'b0;
         retry_q       <= 4'd0;
         timeout_err_q <= 1'b0;
      end else if (soft_req_d) begin
         state_q       <= S_RESET_PLL;
         cnt_q         <= CNT_ZERO;
         pll_rst_q     <= 1'b1;
         sys_rst_q     <= 1'b1;
         ready_q       <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         timeout_err_q <= 1'b0;
         case (state_q)
            S_RESET_PLL: begin
               sys_rst_q <= 1'b1;
               ready_q   <= 1'b0;
               if (cnt_q == HOLD_LAST) begin
                  state_q   <= S_WAIT_LOCK;
                  cnt_q     <= CNT_ZERO;
                  pll_rst_q <= 1'b0;
               end else begin
                  cnt_q     <= cnt_q + CNT_ONE;
                  pll_rst_q <= 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               sys_rst_q <= 1'b1;
               ready_q   <= 1'b0;
               // A lock seen on the timeout cycle takes priority over the retry.
               if (locked_s) begin
                  state_q   <= S_STABLE;
                  cnt_q     <= CNT_ZERO;
                  pll_rst_q <= 1'b0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q       <= S_RESET_PLL;
                  cnt_q         <= CNT_ZERO;
                  pll_rst_q     <= 1'b1;
                  timeout_err_q <= 1'b1;
                  retry_q       <= sat_inc4(retry_q);
               end else begin
                  cnt_q     <= cnt_q + CNT_ONE;
                  pll_rst_q <= 1'b0;
               end
            end
            S_STABLE: begin
               pll_rst_q <= 1'b0;
               if (!locked_s) begin
                  state_q   <= S_WAIT_LOCK;
                  cnt_q     <= CNT_ZERO;
                  sys_rst_q <= 1'b1;
                  ready_q   <= 1'b0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_q   <= S_RUN;
                  cnt_q     <= CNT_ZERO;
                  sys_rst_q <= 1'b0;
                  ready_q   <= 1'b1;
               end else begin
                  cnt_q     <= cnt_q + CNT_ONE;
                  sys_rst_q <= 1'b1;
                  ready_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_q   <= S_RESET_PLL;
                  cnt_q     <= CNT_ZERO;
                  pll_rst_q <= 1'b1;
                  sys_rst_q <= 1'b1;
                  ready_q   <= 1'b0;
                  retry_q   <= sat_inc4(retry_q);
               end else begin
                  pll_rst_q <= 1'b0;
                  sys_rst_q <= 1'b0;
                  ready_q   <= 1'b1;
               end
            end
            default: begin
               state_q   <= S_RESET_PLL;
               cnt_q     <= CNT_ZERO;
               pll_rst_q <= 1'b1;
               sys_rst_q <= 1'b1;
               ready_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst     = sys_rst_q;
   assign ready       = ready_q;
   assign retry_count = retry_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes expected output changes (cycle + value),
// a monitor pops one entry whenever the DUT output tuple changes.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       cpu_reset_n;
   logic       pll_locked;
   logic       soft_rst_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic [3:0] retry_count;
   logic       timeout_err;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t q[$];

   pll_reset_sequencer #(
      .RST_HOLD_CYCLES    (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(32),
      .SYNC_STAGES        (2)
   ) dut (
      .clk         (clk),
      .cpu_reset_n (cpu_reset_n),
      .pll_locked  (pll_locked),
`ifdef PLL_SEQ_SOFT_RST_EN
      .soft_rst_req(soft_rst_req),
`endif
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .retry_count (retry_count),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] sat(input int k);
      return (k > 15) ? 4'd15 : 4'(k);
   endfunction

   task automatic push(input int c, input logic pr, input logic sr, input logic rd,
                       input logic [3:0] rc, input logic te, input string nm);
      exp_t e;
      e.cyc  = c;
      e.val  = {pr, sr, rd, rc, te};
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d events still pending at cycle %0d, required 0 (next %s @%0d)",
                  q.size(), cyc, q[0].name, q[0].cyc);
      end
   endtask

   // Monitor: every change of {pll_rst,sys_rst,ready,retry_count,timeout_err} consumes one expectation.
   logic [7:0] prev = 8'bxxxxxxxx;
   always @(negedge clk) begin
      logic [7:0] cur;
      exp_t e;
      cur = {pll_rst, sys_rst, ready, retry_count, timeout_err};
      if (cur !== prev) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change: got outputs %b at cycle %0d, required no change", cur, cyc);
         end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.val !== cur) begin
               n_bad++;
               $display("FAIL %s: got outputs %b at cycle %0d, required %b at cycle %0d",
                        e.name, cur, cyc, e.val, e.cyc);
            end
         end
         prev = cur;
      end
   end

   initial begin
      int n, l, d, l2, qc, p, w;
      cpu_reset_n  = 1'b0;
      pll_locked   = 1'b0;
      soft_rst_req = 1'b0;
      push(1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "reset_state");

      // Power-up: 4-cycle PLL reset, then lock qualifies after SYNC+STABLE+1 edges.
      step(3);
      n = cyc;
      cpu_reset_n = 1'b1;
      push(n + 4, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "pwrup_pll_rst_end");
      step(10);
      l = cyc;
      pll_locked = 1'b1;
      push(l + 11, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, "pwrup_run");
      drain(40);
      step(3);

      // Lock loss in RUN: retry and a fresh 4-cycle PLL reset.
      d = cyc;
      pll_locked = 1'b0;
      push(d + 3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, "runloss_enter_reset");
      push(d + 7, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, "runloss_pll_rst_end");
      step(10);

      // Relock, then a 3-cycle glitch at stable count 5 restarts qualification.
      l2 = cyc;
      pll_locked = 1'b1;
      step(8);
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      push(l2 + 22, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "glitch_requal_run");
      drain(40);
      step(2);

      // One-cycle cpu_reset_n in RUN: full sequence repeats, retry_count cleared.
      qc = cyc;
      cpu_reset_n = 1'b0;
      push(qc + 1,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "midreset_state");
      push(qc + 5,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "midreset_pll_rst_end");
      push(qc + 14, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, "midreset_run");
      step(1);
      cpu_reset_n = 1'b1;
      drain(40);
      step(2);

`ifdef PLL_SEQ_SOFT_RST_EN
      begin
         int s;
         s = cyc;
         soft_rst_req = 1'b1;
         push(s + 1,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "soft_enter_reset");
         push(s + 5,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "soft_pll_rst_end");
         push(s + 14, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, "soft_run");
         step(1);
         soft_rst_req = 1'b0;
         drain(40);
         step(2);
      end
`endif

      // No lock: timeout every 36 cycles, retry_count saturates at 15.
      p = cyc;
      cpu_reset_n = 1'b0;
      pll_locked  = 1'b0;
      push(p + 1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "nolock_reset");
      push(p + 5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "nolock_pll_rst_end");
      for (int k = 1; k <= 17; k++) begin
         int b;
         b = p + 1 + 36 * k;
         push(b,     1'b1, 1'b1, 1'b0, sat(k), 1'b1, "timeout_pulse");
         push(b + 1, 1'b1, 1'b1, 1'b0, sat(k), 1'b0, "timeout_pulse_end");
         push(b + 4, 1'b0, 1'b1, 1'b0, sat(k), 1'b0, "timeout_pll_rst_end");
      end
      step(1);
      cpu_reset_n = 1'b1;

      // Lock reaching locked_s on the timeout cycle wins over the retry.
      w = p + 1 + 36 * 17 + 4;
      step(w + 29 - cyc);
      pll_locked = 1'b1;
      push(w + 40, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, "lock_beats_timeout_run");
      drain(80);
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
